// File: rtl/serializer_if.sv
// -----------------------------------------------------------------------------
// serializer_if
// Groups the parallel ready/valid handshake and the serial data/valid pair of
// the serializer into one bundle.
//   data_i         : parallel word to send
//   data_mod_i     : number of bits to send, MSB first (0 means full width)
//   data_val_i     : data_i / data_mod_i are valid
//   ready_o        : serializer accepts a word this cycle
//   ser_data_o     : serial bit
//   ser_data_val_o : ser_data_o is valid
//   ser_ready_i    : consumer takes the presented bit (only when
//                    SERIALIZER_BACKPRESSURE_EN is defined)
// Modports: slave = the serializer, master = its environment.
// -----------------------------------------------------------------------------
interface serializer_if #(
   parameter int DATA_BUS_WIDTH = 16
) ();
   localparam int MOD_WIDTH = $clog2(DATA_BUS_WIDTH) + 1;

   logic [DATA_BUS_WIDTH-1:0] data_i;
   logic [MOD_WIDTH-1:0]      data_mod_i;
   logic                      data_val_i;
   logic                      ready_o;
   logic                      ser_data_o;
   logic                      ser_data_val_o;
`ifdef SERIALIZER_BACKPRESSURE_EN
   logic                      ser_ready_i;

   modport slave (
      input  data_i, data_mod_i, data_val_i, ser_ready_i,
      output ready_o, ser_data_o, ser_data_val_o
   );

   modport master (
      output data_i, data_mod_i, data_val_i, ser_ready_i,
      input  ready_o, ser_data_o, ser_data_val_o
   );
`else
   modport slave (
      input  data_i, data_mod_i, data_val_i,
      output ready_o, ser_data_o, ser_data_val_o
   );

   modport master (
      output data_i, data_mod_i, data_val_i,
      input  ready_o, ser_data_o, ser_data_val_o
   );
`endif
endinterface

// File: rtl/serializer.sv
// -----------------------------------------------------------------------------
// serializer
// Takes a parallel word plus a bit count over a ready/valid handshake and
// shifts N bits out MSB first, one per cycle, as a registered serial
// data/valid pair. A new word can be accepted in the cycle the last bit of the
// current word is presented, so consecutive words stream with no gap.
//
// Ports:
//   clk_i    : clock, rising edge
//   arst_n_i : asynchronous active-low reset
//   bus      : serializer_if.slave (parallel handshake + serial pair)
//
// Optional feature (macro SERIALIZER_BACKPRESSURE_EN): adds bus.ser_ready_i;
// a presented bit only advances when the consumer takes it, and the serial
// outputs hold while it does not.
// -----------------------------------------------------------------------------
module serializer #(
   parameter int DATA_BUS_WIDTH = 16,
   parameter int MOD_WIDTH      = $clog2(DATA_BUS_WIDTH) + 1
) (
   input  logic         clk_i,
   input  logic         arst_n_i,
   serializer_if.slave  bus
);

   localparam logic [MOD_WIDTH-1:0] FULL_N = MOD_WIDTH'(DATA_BUS_WIDTH);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t                    state_q;
   logic [DATA_BUS_WIDTH-1:0] shift_q;     // current bit sits at the MSB
   logic [MOD_WIDTH-1:0]      cnt_q;       // bits presented so far, 1..N
   logic [MOD_WIDTH-1:0]      n_q;         // effective length of current word
   logic                      ser_data_q;
   logic                      ser_val_q;

   logic [MOD_WIDTH-1:0]      n_d;
   logic                      ser_ready_s;
   logic                      last_s;
   logic                      ready_s;
   logic                      accept_s;

`ifdef SERIALIZER_BACKPRESSURE_EN
   assign ser_ready_s = bus.ser_ready_i;
`else
   assign ser_ready_s = 1'b1;
`endif

   // Effective bit count: 0 and anything above the bus width mean a full word.
   always_comb begin
      if ((bus.data_mod_i == {MOD_WIDTH{1'b0}}) || (bus.data_mod_i > FULL_N)) begin
         n_d = FULL_N;
      end else begin
         n_d = bus.data_mod_i;
      end
   end

   assign last_s = (state_q == ST_SHIFT) && (cnt_q == n_q);

   // ready depends only on state, counter and consumer, never on data_val_i.
   always_comb begin
      case (state_q)
         ST_IDLE:  ready_s = 1'b1;
         ST_SHIFT: ready_s = last_s && ser_ready_s;
         default:  ready_s = 1'b0;
      endcase
   end

   assign accept_s = bus.data_val_i && ready_s;

   // Control FSM with shift register, counter and registered serial outputs.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state_q    <= ST_IDLE;
         shift_q    <= {DATA_BUS_WIDTH{1'b0}};
         cnt_q      <= {MOD_WIDTH{1'b0}};
         n_q        <= {MOD_WIDTH{1'b0}};
         ser_data_q <= 1'b0;
         ser_val_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept_s) begin
                  state_q    <= ST_SHIFT;
                  shift_q    <= bus.data_i;
                  n_q        <= n_d;
                  cnt_q      <= MOD_WIDTH'(1);
                  ser_data_q <= bus.data_i[DATA_BUS_WIDTH-1];
                  ser_val_q  <= 1'b1;
               end
            end
            ST_SHIFT: begin
               if (accept_s) begin
                  // Reload on the last-bit cycle: first bit of the next word
                  // follows directly.
                  shift_q    <= bus.data_i;
                  n_q        <= n_d;
                  cnt_q      <= MOD_WIDTH'(1);
                  ser_data_q <= bus.data_i[DATA_BUS_WIDTH-1];
                  ser_val_q  <= 1'b1;
               end else if (ser_ready_s) begin
                  if (cnt_q == n_q) begin
                     state_q    <= ST_IDLE;
                     shift_q    <= {DATA_BUS_WIDTH{1'b0}};
                     cnt_q      <= {MOD_WIDTH{1'b0}};
                     ser_data_q <= 1'b0;
                     ser_val_q  <= 1'b0;
                  end else begin
                     shift_q    <= {shift_q[DATA_BUS_WIDTH-2:0], 1'b0};
                     cnt_q      <= cnt_q + MOD_WIDTH'(1);
                     ser_data_q <= shift_q[DATA_BUS_WIDTH-2];
                  end
               end
            end
            default: begin
               state_q    <= ST_IDLE;
               shift_q    <= {DATA_BUS_WIDTH{1'b0}};
               cnt_q      <= {MOD_WIDTH{1'b0}};
               n_q        <= {MOD_WIDTH{1'b0}};
               ser_data_q <= 1'b0;
               ser_val_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ready_o        = ready_s;
   assign bus.ser_data_o     = ser_data_q;
   assign bus.ser_data_val_o = ser_val_q;

endmodule

// File: tb/tb_serializer.sv
// -----------------------------------------------------------------------------
// tb_serializer
// Drives words into the serializer and checks the serial stream against a
// queue model: every accepted word appends its N bits (MSB first) to a queue of
// bits still owed; each consumed bit pops the front. The stream must be valid
// whenever bits are owed, show the front bit, and ready must be high exactly
// when at most the final owed bit remains (and the consumer takes it).
// -----------------------------------------------------------------------------
module tb_serializer;
   localparam int W  = 16;
   localparam int MW = $clog2(W) + 1;

   logic clk = 1'b0;
   logic arst_n = 1'b0;
   logic ser_ready = 1'b1;
   logic bp_rand = 1'b0;

   int tests = 0;
   int fails = 0;

   bit exp_q[$];   // bits owed by the DUT, front = currently presented
   bit obs[$];     // bits actually consumed from the DUT

   logic          acc_pend = 1'b0;
   logic [W-1:0]  acc_data = '0;
   logic [MW-1:0] acc_mod = '0;
   logic          cons_pend = 1'b0;

   serializer_if #(.DATA_BUS_WIDTH(W)) bus ();

`ifdef SERIALIZER_BACKPRESSURE_EN
   assign bus.ser_ready_i = ser_ready;
`endif

   serializer #(.DATA_BUS_WIDTH(W)) dut (
      .clk_i    (clk),
      .arst_n_i (arst_n),
      .bus      (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int eff_n(input logic [MW-1:0] m);
      if (m == 0 || m > W) return W;
      return int'(m);
   endfunction

   function automatic logic [63:0] pack_obs();
      logic [63:0] v = 64'd0;
      foreach (obs[i]) v = {v[62:0], obs[i]};
      return v;
   endfunction

   // Mid-cycle: check ready, and note what the next edge will accept/consume.
   always @(negedge clk) begin
      if (arst_n) begin
         logic exp_ready;
         exp_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && ser_ready);
         chk("ready", bus.ready_o, exp_ready);
         acc_pend  = bus.data_val_i && exp_ready;
         acc_data  = bus.data_i;
         acc_mod   = bus.data_mod_i;
         cons_pend = (exp_q.size() > 0) && ser_ready;
         if (bus.ser_data_val_o && ser_ready) obs.push_back(bus.ser_data_o);
      end else begin
         acc_pend  = 1'b0;
         cons_pend = 1'b0;
      end
   end

   // Just after each edge: advance the model, then check the serial outputs.
   always @(posedge clk) begin
      #1;
      if (!arst_n) begin
         exp_q.delete();
      end else begin
         if (cons_pend) void'(exp_q.pop_front());
         if (acc_pend)
            for (int i = 0; i < eff_n(acc_mod); i++) exp_q.push_back(acc_data[W-1-i]);
         acc_pend  = 1'b0;
         cons_pend = 1'b0;
         chk("ser_val", bus.ser_data_val_o, exp_q.size() > 0);
         if (exp_q.size() > 0) chk("ser_data", bus.ser_data_o, exp_q[0]);
         else                  chk("ser_data_idle", bus.ser_data_o, 1'b0);
      end
   end

`ifdef SERIALIZER_BACKPRESSURE_EN
   always @(posedge clk) begin
      if (bp_rand) begin
         #3;
         ser_ready = ($urandom_range(0, 3) != 0);
      end
   end
`endif

   // Present a word (caller is at posedge+3) and return once it was taken,
   // again at posedge+3; data_val_i is left high for back-to-back use.
   task automatic send(input logic [W-1:0] d, input logic [MW-1:0] m);
      bit taken = 1'b0;
      bus.data_i     = d;
      bus.data_mod_i = m;
      bus.data_val_i = 1'b1;
      for (int i = 0; i < 200 && !taken; i++) begin
         @(negedge clk);
         if (bus.ready_o) taken = 1'b1;
         @(posedge clk);
         #3;
      end
      if (!taken) chk("send_timeout", 1'b0, 1'b1);
   endtask

   task automatic drop();
      bus.data_val_i = 1'b0;
   endtask

   task automatic wait_idle();
      bit idle = 1'b0;
      for (int i = 0; i < 400 && !idle; i++) begin
         @(posedge clk);
         #3;
         if (!bus.ser_data_val_o && exp_q.size() == 0) idle = 1'b1;
      end
      if (!idle) chk("idle_timeout", 1'b0, 1'b1);
   endtask

   initial begin
      bus.data_i     = '0;
      bus.data_mod_i = '0;
      bus.data_val_i = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      arst_n = 1'b1;
      #1;
      chk("rst_ready", bus.ready_o, 1'b1);
      chk("rst_val", bus.ser_data_val_o, 1'b0);
      chk("rst_data", bus.ser_data_o, 1'b0);
      @(posedge clk);
      #3;

      // Single full word
      obs.delete();
      send(16'hA5C3, 5'd0);
      drop();
      wait_idle();
      chk("a5c3_len", obs.size(), 16);
      chk("a5c3_bits", pack_obs(), 64'hA5C3);

      // Back-to-back full words
      obs.delete();
      send(16'hFFFF, 5'd0);
      send(16'h0000, 5'd0);
      drop();
      wait_idle();
      chk("b2b_len", obs.size(), 32);
      chk("b2b_bits", pack_obs(), 64'hFFFF0000);

      // Short counts, then clamped count
      obs.delete();
      send(16'hC000, 5'd3);
      send(16'hC000, 5'd1);
      drop();
      wait_idle();
      chk("mod3_1_len", obs.size(), 4);
      chk("mod3_1_bits", pack_obs(), 64'hD);
      obs.delete();
      send(16'hC000, 5'd20);
      drop();
      wait_idle();
      chk("mod20_len", obs.size(), 16);
      chk("mod20_bits", pack_obs(), 64'hC000);

      // Word offered while busy is dropped
      obs.delete();
      send(16'h5A5A, 5'd0);
      drop();
      repeat (4) begin @(posedge clk); #3; end
      bus.data_i     = 16'h1234;
      bus.data_mod_i = 5'd0;
      bus.data_val_i = 1'b1;
      @(posedge clk);
      #3;
      drop();
      wait_idle();
      chk("busy_drop_len", obs.size(), 16);
      chk("busy_drop_bits", pack_obs(), 64'h5A5A);

      // Asynchronous reset in the middle of a word
      send(16'h3C3C, 5'd0);
      drop();
      repeat (6) begin @(posedge clk); #3; end
      arst_n = 1'b0;
      #1;
      chk("arst_val", bus.ser_data_val_o, 1'b0);
      chk("arst_data", bus.ser_data_o, 1'b0);
      @(posedge clk);
      #3;
      arst_n = 1'b1;
      #1;
      chk("arst_ready", bus.ready_o, 1'b1);
      @(posedge clk);
      #3;
      obs.delete();
      send(16'h9E71, 5'd0);
      drop();
      wait_idle();
      chk("after_rst_len", obs.size(), 16);
      chk("after_rst_bits", pack_obs(), 64'h9E71);

`ifdef SERIALIZER_BACKPRESSURE_EN
      // Consumer stalls on the first bit
      obs.delete();
      send(16'h8001, 5'd0);
      drop();
      ser_ready = 1'b0;
      chk("bp_hold_val", bus.ser_data_val_o, 1'b1);
      chk("bp_hold_data", bus.ser_data_o, 1'b1);
      repeat (2) begin
         @(posedge clk);
         #1;
         chk("bp_hold_val", bus.ser_data_val_o, 1'b1);
         chk("bp_hold_data", bus.ser_data_o, 1'b1);
         #2;
      end
      ser_ready = 1'b1;
      wait_idle();
      chk("bp_word", pack_obs(), 64'h8001);
      bp_rand = 1'b1;
`endif

      // Randomized traffic against the model
      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 3) == 0) begin
            drop();
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #3; end
         end else begin
            send(W'($urandom), MW'($urandom_range(0, 31)));
         end
      end
      drop();
      bp_rand = 1'b0;
      @(posedge clk);
      #3;
      ser_ready = 1'b1;
      wait_idle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
